ps2_mouse_packet_rx: RTL and testbench

- Front end of the mouse path: a PS/2 receiver in the `clock_100Mhz` domain.
- Synchronises and filters the raw `Mouse_Clk`/`Mouse_Data` pins, frames 11-bit PS/2 words and aligns 3-byte movement packets.
- Presents each packet as status byte plus sign-extended 9-bit X/Y deltas, with a valid/ack handshake.
- Feeds the position-accumulation and 7-segment display stage, replacing its direct clocking from the mouse clock pin.

---
 rtl/ps2_mouse_packet_rx.sv | 192 +++++++++++++++++++
 tb/tb_ps2_mouse_packet_rx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_packet_rx.sv
// PS/2 mouse receiver: pin conditioning, 11-bit framing and 3-byte packet alignment with valid/ack.
// Optional build macro PS2_PARITY_CHECK_EN enables odd-parity rejection of received bytes.
module ps2_mouse_packet_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clock_100Mhz,
  input  logic       reset,
  input  logic       Mouse_Clk,
  input  logic       Mouse_Data,
  input  logic       packet_ack,
  output logic       packet_valid,
  output logic [7:0] status_byte,
  output logic [8:0] x_delta,
  output logic [8:0] y_delta,
  output logic       frame_error,
  output logic       overrun
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_s, dat_s;
  logic [FW-1:0]          flt_cnt;
  logic                   filt, filt_d, fall;
  logic [TW-1:0]          tmo_cnt;
  logic                   busy, timeout;

  state_t                 state_q, state_d;
  logic [7:0]             shift_q;
  logic [2:0]             bit_cnt_q;
  logic                   frame_ok, byte_ok, byte_bad;

  logic [1:0]             idx_q;
  logic [7:0]             byte0_q, byte1_q;
  logic                   align_drop, pkt_done;

  // Idle PS/2 lines float high, so the synchronisers reset to 1 to avoid a spurious edge.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], Mouse_Clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], Mouse_Data};
    end
  end

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      flt_cnt <= '0;
      filt    <= 1'b1;
      filt_d  <= 1'b1;
      fall    <= 1'b0;
    end else begin
      if (clk_s == filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        filt    <= clk_s;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
      filt_d <= filt;
      fall   <= filt_d & ~filt;
    end
  end

  // Counter saturates, so an expired idle period raises at most one timeout.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (fall) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TW'(TIMEOUT_CYCLES)) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign busy    = (state_q != IDLE) || (idx_q != 2'd0);
  assign timeout = busy && !fall && (tmo_cnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: a default before any branch keeps combinational blocks free of inferred latches.
    state_d = state_q;
    if (timeout) begin
      state_d = IDLE;
    end else if (fall) begin
      case (state_q)
        IDLE:    if (!dat_s) state_d = DATA;
        DATA:    if (bit_cnt_q == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
    end else if (fall) begin
      case (state_q)
        IDLE: bit_cnt_q <= 3'd0;
        DATA: begin
          shift_q   <= {dat_s, shift_q[7:1]};
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic parity_q;

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset)                          parity_q <= 1'b0;
    else if (fall && state_q == PARITY) parity_q <= dat_s;
  end

  assign frame_ok = dat_s && (^{shift_q, parity_q});
`else
  assign frame_ok = dat_s;
`endif

  always_comb begin
    byte_ok  = 1'b0;
    byte_bad = 1'b0;
    if (fall && state_q == STOP) begin
      if (frame_ok) byte_ok  = 1'b1;
      else          byte_bad = 1'b1;
    end
  end

  // Byte 0 always carries bit 3 set; anything else at index 0 is a misaligned stream.
  assign align_drop = byte_ok && (idx_q == 2'd0) && !shift_q[3];
  assign pkt_done   = byte_ok && (idx_q == 2'd2);

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      idx_q   <= 2'd0;
      byte0_q <= 8'h00;
      byte1_q <= 8'h00;
    end else if (timeout) begin
      idx_q <= 2'd0;
    end else if (byte_ok && !align_drop) begin
      case (idx_q)
        2'd0: begin byte0_q <= shift_q; idx_q <= 2'd1; end
        2'd1: begin byte1_q <= shift_q; idx_q <= 2'd2; end
        default: idx_q <= 2'd0;
      endcase
    end
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      packet_valid <= 1'b0;
      status_byte  <= 8'h00;
      x_delta      <= 9'h000;
      y_delta      <= 9'h000;
      frame_error  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      frame_error <= byte_bad | align_drop | timeout;
      overrun     <= pkt_done & packet_valid & ~packet_ack;
      if (pkt_done) begin
        packet_valid <= 1'b1;
        status_byte  <= byte0_q;
        x_delta      <= {byte0_q[4], byte1_q};
        y_delta      <= {byte0_q[5], shift_q};
      end else if (packet_ack) begin
        packet_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_packet_rx.sv
// Self-checking bench for ps2_mouse_packet_rx: directed scenarios plus randomized packets
// compared against a frame-level reference model.
`timescale 1ns/1ps
module tb_ps2_mouse_packet_rx;

  localparam int SYNC    = 2;
  localparam int FLT     = 8;
  localparam int TMO     = 600;
  localparam int HALF    = 25;
  localparam int GAP     = 60;
  localparam int LAT     = SYNC + FLT + 1;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mouse_clk = 1'b1;
  logic       mouse_data = 1'b1;
  logic       packet_ack = 1'b0;
  logic       packet_valid;
  logic [7:0] status_byte;
  logic [8:0] x_delta, y_delta;
  logic       frame_error, overrun;

  ps2_mouse_packet_rx #(.SYNC_STAGES(SYNC), .FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO)) dut (
    .clock_100Mhz(clk),
    .reset       (reset),
    .Mouse_Clk   (mouse_clk),
    .Mouse_Data  (mouse_data),
    .packet_ack  (packet_ack),
    .packet_valid(packet_valid),
    .status_byte (status_byte),
    .x_delta     (x_delta),
    .y_delta     (y_delta),
    .frame_error (frame_error),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int err_seen = 0;
  int ovr_seen = 0;

  // Reference model: frame-level view of the receiver.
  int         exp_err = 0;
  int         exp_ovr = 0;
  int         m_idx = 0;
  logic [7:0] m_buf [3];
  bit         m_valid = 1'b0;
  logic [7:0] m_status = 8'h00;
  logic [8:0] m_x = 9'h000;
  logic [8:0] m_y = 9'h000;

  always @(negedge clk) begin
    if (!reset) begin
      if (frame_error) err_seen++;
      if (overrun)     ovr_seen++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] to9(input bit neg, input logic [7:0] mag);
    int v;
    v = neg ? int'(mag) - 256 : int'(mag);
    return v[8:0];
  endfunction

  // Drives nbits of an 11-bit frame; optionally pulses ack in the cycle the stop bit completes.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input bit ack_stop);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      mouse_data = fr[i];
      repeat (HALF) @(negedge clk);
      mouse_clk = 1'b0;
      if (i == 10 && ack_stop) begin
        repeat (LAT) @(negedge clk);
        packet_ack = 1'b1;
        @(negedge clk);
        packet_ack = 1'b0;
        repeat (HALF - LAT - 1) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      mouse_clk = 1'b1;
    end
    mouse_data = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic model_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit ack_stop);
    if (bad_stop || (bad_par && PAR_EN)) begin
      exp_err++;
    end else if (m_idx == 0 && !b[3]) begin
      exp_err++;
    end else begin
      m_buf[m_idx] = b;
      m_idx++;
      if (m_idx == 3) begin
        m_idx = 0;
        if (m_valid && !ack_stop) exp_ovr++;
        m_valid  = 1'b1;
        m_status = m_buf[0];
        m_x      = to9(m_buf[0][4], m_buf[1]);
        m_y      = to9(m_buf[0][5], m_buf[2]);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                           input bit ack_stop);
    send_frame(b, bad_par, bad_stop, 11, ack_stop);
    model_byte(b, bad_par, bad_stop, ack_stop);
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b0, 1'b0, 1'b0);
    send_byte(b1, 1'b0, 1'b0, 1'b0);
    send_byte(b2, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_state(input string tag);
    check({tag, ".valid"},   32'(packet_valid), 32'(m_valid));
    check({tag, ".status"},  32'(status_byte),  32'(m_status));
    check({tag, ".x"},       32'(x_delta),      32'(m_x));
    check({tag, ".y"},       32'(y_delta),      32'(m_y));
    check({tag, ".errs"},    32'(err_seen),     32'(exp_err));
    check({tag, ".overrun"}, 32'(ovr_seen),     32'(exp_ovr));
  endtask

  task automatic do_ack(input string tag);
    packet_ack = 1'b1;
    @(negedge clk);
    packet_ack = 1'b0;
    m_valid = 1'b0;
    check({tag, ".ack_clear"}, 32'(packet_valid), 32'(m_valid));
  endtask

  task automatic idle_timeout();
    repeat (TMO + 200) @(negedge clk);
  endtask

  initial begin
    logic [7:0] r0, r1, r2;
    bit         bs1, bp2;

    repeat (4) @(negedge clk);
    check("reset.valid",  32'(packet_valid), 32'd0);
    check("reset.ferr",   32'(frame_error),  32'd0);
    check("reset.ovr",    32'(overrun),      32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check_state("reset");

    send_packet(8'h08, 8'h05, 8'h03);
    check_state("clean");
    check("clean.x_value", 32'(x_delta), 32'h005);
    repeat (200) @(negedge clk);
    check("clean.held", 32'(packet_valid), 32'd1);
    do_ack("clean");

    send_packet(8'h38, 8'hFB, 8'hF0);
    check_state("negative");
    check("negative.x_value", 32'(x_delta), 32'h1FB);
    check("negative.y_value", 32'(y_delta), 32'h1F0);

    // Misaligned byte first; the held packet is still unacknowledged, so the next one overruns.
    send_byte(8'h05, 1'b0, 1'b0, 1'b0);
    check_state("misalign.drop");
    send_packet(8'h08, 8'h01, 8'h02);
    check_state("misalign.overrun");
    do_ack("misalign");

    send_byte(8'h09, 1'b0, 1'b0, 1'b0);
    send_byte(8'h10, 1'b1, 1'b0, 1'b0);
    send_byte(8'h20, 1'b0, 1'b0, 1'b0);
    check_state("bad_parity");
    send_byte(8'h2C, 1'b0, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0, 1'b0);
    check_state("bad_parity.tail");
    idle_timeout();
    if (m_idx != 0) exp_err++;
    m_idx = 0;
    check_state("bad_parity.flush");
    if (m_valid) do_ack("bad_parity");

    send_byte(8'h18, 1'b0, 1'b0, 1'b0);
    send_byte(8'h44, 1'b0, 1'b0, 1'b0);
    idle_timeout();
    exp_err++;
    m_idx = 0;
    check_state("timeout.bytes");
    send_frame(8'hA5, 1'b0, 1'b0, 4, 1'b0);
    idle_timeout();
    exp_err++;
    check_state("timeout.partial");
    send_packet(8'h28, 8'h7F, 8'h80);
    check_state("timeout.recover");

    send_byte(8'h08, 1'b0, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0, 1'b0);
    send_byte(8'h44, 1'b0, 1'b0, 1'b1);
    check_state("same_cycle_ack");
    do_ack("same_cycle_ack");

    send_byte(8'h08, 1'b0, 1'b0, 1'b0);
    for (int g = 5; g <= FLT - 1; g += FLT - 6) begin
      mouse_data = 1'b0;
      repeat (4) @(negedge clk);
      mouse_clk = 1'b0;
      repeat (g) @(negedge clk);
      mouse_clk = 1'b1;
      repeat (4) @(negedge clk);
      mouse_data = 1'b1;
      repeat (GAP) @(negedge clk);
    end
    send_byte(8'h66, 1'b0, 1'b0, 1'b0);
    send_byte(8'h77, 1'b0, 1'b0, 1'b0);
    check_state("glitch");
    do_ack("glitch");

    send_byte(8'h08, 1'b0, 1'b0, 1'b0);
    send_byte(8'h12, 1'b0, 1'b1, 1'b0);
    check_state("bad_stop");
    idle_timeout();
    exp_err++;
    m_idx = 0;

    send_packet(8'h19, 8'h02, 8'h03);
    send_frame(8'h08, 1'b0, 1'b0, 5, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    m_valid = 1'b0; m_status = 8'h00; m_x = 9'h000; m_y = 9'h000; m_idx = 0;
    check_state("mid_reset");
    reset = 1'b0;
    repeat (10) @(negedge clk);
    send_packet(8'h3C, 8'h80, 8'h7F);
    check_state("after_reset");
    do_ack("after_reset");

    for (int p = 0; p < 10; p++) begin
      r0  = 8'($urandom) | 8'h08;
      r1  = 8'($urandom);
      r2  = 8'($urandom);
      bs1 = ($urandom_range(0, 7) == 0);
      bp2 = ($urandom_range(0, 5) == 0);
      send_byte(r0, 1'b0, 1'b0, 1'b0);
      send_byte(r1, 1'b0, bs1, 1'b0);
      send_byte(r2, bp2, 1'b0, 1'b0);
      check_state($sformatf("rand%0d", p));
      if (m_valid && $urandom_range(0, 1) == 1) do_ack($sformatf("rand%0d", p));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
